pong_frame_renderer: RTL and testbench

Per-pixel colour generator for the Pong playfield, successor to the fixed 20x15 builder. Maps VGA pixel coordinates to a cell grid and paints ball, two paddles, optional dashed centre net and background from parameterised colours. Object positions are latched once per frame to prevent tearing. After a score, a frame-counted blink hides the ball on alternate frames. Sits between the game-logic FSM and the VGA sync/DAC output stage.

---
 rtl/pong_pkg.sv | 26 ++
 rtl/pong_flash_ctrl.sv | 38 +++
 rtl/pong_frame_renderer.sv | 132 +++++++++++++
 tb/tb_pong_frame_renderer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared constants for the Pong renderer: colours, grid defaults and derived widths.
package pong_pkg;

  localparam int RGB_W            = 8;
  localparam int COORD_W          = 10;
  localparam int CELL_SHIFT_DEF   = 5;
  localparam int GRID_W_DEF       = 20;
  localparam int GRID_H_DEF       = 15;
  localparam int PADDLE_LEN_DEF   = 5;
  localparam int FLASH_FRAMES_DEF = 60;
  localparam int XW_DEF           = $clog2(GRID_W_DEF);
  localparam int YW_DEF           = $clog2(GRID_H_DEF);

  localparam logic [RGB_W-1:0] COL_BALL_DEF   = 8'hFF;
  localparam logic [RGB_W-1:0] COL_PADDLE_DEF = 8'hFF;
  localparam logic [RGB_W-1:0] COL_NET_DEF    = 8'h92;
  localparam logic [RGB_W-1:0] COL_BG_DEF     = 8'h00;

  typedef enum logic [1:0] {
    PIX_BG,
    PIX_NET,
    PIX_PADDLE,
    PIX_BALL
  } pix_kind_t;

endpackage

// File: rtl/pong_flash_ctrl.sv
// Post-score blink counter; the ball visibility is frozen at each frame_start.
module pong_flash_ctrl
  import pong_pkg::*;
#(
  parameter int  FLASH_FRAMES = FLASH_FRAMES_DEF,
  localparam int CW           = $clog2(FLASH_FRAMES + 1)
) (
  input  logic CLK_IN,
  input  logic RST_N_IN,
  input  logic frame_start,
  input  logic score_evt,
  output logic ball_visible_s
);

  logic [CW-1:0] flash_cnt;
  logic [CW-1:0] cnt_next;

  // A score reload beats a same-cycle frame decrement.
  always_comb begin
    cnt_next = flash_cnt;
    if (score_evt)
      cnt_next = CW'(FLASH_FRAMES);
    else if (frame_start && (flash_cnt != '0))
      cnt_next = flash_cnt - CW'(1);
  end

  always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      flash_cnt      <= '0;
      ball_visible_s <= 1'b1;
    end else begin
      flash_cnt <= cnt_next;
      if (frame_start)
        ball_visible_s <= (cnt_next == '0) || !cnt_next[0];
    end
  end

endmodule

// File: rtl/pong_frame_renderer.sv
// Per-pixel Pong playfield colour generator with frame-latched object positions.
module pong_frame_renderer
  import pong_pkg::*;
#(
  parameter int               CELL_SHIFT   = CELL_SHIFT_DEF,
  parameter int               GRID_W       = GRID_W_DEF,
  parameter int               GRID_H       = GRID_H_DEF,
  parameter int               PADDLE_LEN   = PADDLE_LEN_DEF,
  parameter int               FLASH_FRAMES = FLASH_FRAMES_DEF,
  parameter logic [RGB_W-1:0] COL_BALL     = COL_BALL_DEF,
  parameter logic [RGB_W-1:0] COL_PADDLE   = COL_PADDLE_DEF,
  parameter logic [RGB_W-1:0] COL_NET      = COL_NET_DEF,
  parameter logic [RGB_W-1:0] COL_BG       = COL_BG_DEF,
  localparam int              XW           = $clog2(GRID_W),
  localparam int              YW           = $clog2(GRID_H)
) (
  input  logic               CLK_IN,
  input  logic               RST_N_IN,
  input  logic               frame_start,
  input  logic               active,
  input  logic [COORD_W-1:0] xCoord,
  input  logic [COORD_W-1:0] yCoord,
  input  logic [XW-1:0]      ballX,
  input  logic [YW-1:0]      ballY,
  input  logic [YW-1:0]      playerPos,
  input  logic [YW-1:0]      comPos,
  input  logic               score_evt,
  input  logic               net_en,
  output logic [RGB_W-1:0]   RGB_out,
  output logic               rgb_valid
);

  localparam int EW = COORD_W + 1;

  logic [XW-1:0]      ball_x_s;
  logic [YW-1:0]      ball_y_s;
  logic [YW-1:0]      player_pos_s;
  logic [YW-1:0]      com_pos_s;
  logic               net_en_s;
  logic               ball_visible_s;
  logic [COORD_W-1:0] cx_q;
  logic [COORD_W-1:0] cy_q;
  logic               act_q;

  always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      ball_x_s     <= '0;
      ball_y_s     <= '0;
      player_pos_s <= '0;
      com_pos_s    <= '0;
      net_en_s     <= 1'b0;
    end else if (frame_start) begin
      ball_x_s     <= ballX;
      ball_y_s     <= ballY;
      player_pos_s <= playerPos;
      com_pos_s    <= comPos;
      net_en_s     <= net_en;
    end
  end

  pong_flash_ctrl #(
    .FLASH_FRAMES(FLASH_FRAMES)
  ) u_flash (
    .CLK_IN        (CLK_IN),
    .RST_N_IN      (RST_N_IN),
    .frame_start   (frame_start),
    .score_evt     (score_evt),
    .ball_visible_s(ball_visible_s)
  );

  always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      cx_q  <= '0;
      cy_q  <= '0;
      act_q <= 1'b0;
    end else begin
      cx_q  <= xCoord >> CELL_SHIFT;
      cy_q  <= yCoord >> CELL_SHIFT;
      act_q <= active;
    end
  end

  // One extra bit so paddle spans near the bottom edge never wrap.
  logic [EW-1:0] cx_e, cy_e, pl_top, pl_bot, cm_top, cm_bot;
  logic          in_grid, ball_hit, paddle_hit, net_hit;
  pix_kind_t     kind;
  logic [RGB_W-1:0] colour;

  assign cx_e   = EW'(cx_q);
  assign cy_e   = EW'(cy_q);
  assign pl_top = EW'(player_pos_s);
  assign pl_bot = pl_top + EW'(PADDLE_LEN - 1);
  assign cm_top = EW'(com_pos_s);
  assign cm_bot = cm_top + EW'(PADDLE_LEN - 1);

  assign in_grid    = (cx_e < EW'(GRID_W)) && (cy_e < EW'(GRID_H));
  assign ball_hit   = ball_visible_s && (cx_e == EW'(ball_x_s)) && (cy_e == EW'(ball_y_s));
  assign paddle_hit = ((cx_e == '0) && (cy_e >= pl_top) && (cy_e <= pl_bot)) ||
                      ((cx_e == EW'(GRID_W - 1)) && (cy_e >= cm_top) && (cy_e <= cm_bot));
  assign net_hit    = net_en_s && (cx_e == EW'(GRID_W / 2)) && !cy_e[0];

  always_comb begin
    kind = PIX_BG;
    if (in_grid) begin
      if (ball_hit)
        kind = PIX_BALL;
      else if (paddle_hit)
        kind = PIX_PADDLE;
      else if (net_hit)
        kind = PIX_NET;
    end
    case (kind)
      PIX_BALL:   colour = COL_BALL;
      PIX_PADDLE: colour = COL_PADDLE;
      PIX_NET:    colour = COL_NET;
      default:    colour = COL_BG;
    endcase
    if (!act_q)
      colour = '0;
  end

  always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      RGB_out   <= '0;
      rgb_valid <= 1'b0;
    end else begin
      RGB_out   <= colour;
      rgb_valid <= act_q;
    end
  end

endmodule

// File: tb/tb_pong_frame_renderer.sv
// Randomised plus directed bench for pong_frame_renderer against a cell-level playfield model.
module tb_pong_frame_renderer;

  localparam int FLASH = 4;
  localparam int CELL  = 32;
  localparam int GW    = 20;
  localparam int GH    = 15;
  localparam int PLEN  = 5;

  logic       CLK_IN = 1'b0;
  logic       RST_N_IN = 1'b0;
  logic       frame_start = 1'b0;
  logic       active = 1'b0;
  logic [9:0] xCoord = '0;
  logic [9:0] yCoord = '0;
  logic [4:0] ballX = '0;
  logic [3:0] ballY = '0;
  logic [3:0] playerPos = '0;
  logic [3:0] comPos = '0;
  logic       score_evt = 1'b0;
  logic       net_en = 1'b0;
  logic [7:0] RGB_out;
  logic       rgb_valid;

  int checks = 0;
  int errors = 0;

  int         m_bx, m_by, m_pp, m_cp, m_cnt;
  bit         m_net, m_vis;
  logic [8:0] pending;

  pong_frame_renderer #(
    .FLASH_FRAMES(FLASH)
  ) dut (
    .CLK_IN     (CLK_IN),
    .RST_N_IN   (RST_N_IN),
    .frame_start(frame_start),
    .active     (active),
    .xCoord     (xCoord),
    .yCoord     (yCoord),
    .ballX      (ballX),
    .ballY      (ballY),
    .playerPos  (playerPos),
    .comPos     (comPos),
    .score_evt  (score_evt),
    .net_en     (net_en),
    .RGB_out    (RGB_out),
    .rgb_valid  (rgb_valid)
  );

  always #5 CLK_IN = ~CLK_IN;

  function automatic int px(int c);
    return c * CELL + int'($urandom_range(0, CELL - 1));
  endfunction

  function automatic logic [7:0] model_pixel(int x, int y, bit act);
    int cx = x / CELL;
    int cy = y / CELL;
    if (!act) return 8'h00;
    if (cx >= GW || cy >= GH) return 8'h00;
    if (m_vis && cx == m_bx && cy == m_by) return 8'hFF;
    if (cx == 0 && cy >= m_pp && cy < m_pp + PLEN) return 8'hFF;
    if (cx == GW - 1 && cy >= m_cp && cy < m_cp + PLEN) return 8'hFF;
    if (m_net && cx == GW / 2 && (cy % 2) == 0) return 8'h92;
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_bx = 0; m_by = 0; m_pp = 0; m_cp = 0; m_net = 0;
    m_cnt = 0; m_vis = 1; pending = '0;
  endtask

  task automatic checkOutput(string tag, logic [8:0] obs, logic [8:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got valid/rgb %h, expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; drives one pixel cycle and checks the output from the previous one.
  task automatic applyStimulus(string tag, int x, int y, bit act, bit fs, bit se);
    logic [8:0] e;
    xCoord = x[9:0];
    yCoord = y[9:0];
    active = act;
    frame_start = fs;
    score_evt = se;
    if (se) m_cnt = FLASH;
    else if (fs && m_cnt != 0) m_cnt = m_cnt - 1;
    if (fs) begin
      m_bx = ballX; m_by = ballY; m_pp = playerPos; m_cp = comPos; m_net = net_en;
      m_vis = (m_cnt == 0) || (m_cnt % 2 == 0);
    end
    e = {act, model_pixel(x, y, act)};
    @(posedge CLK_IN);
    #1;
    checkOutput(tag, {rgb_valid, RGB_out}, pending);
    pending = e;
    @(negedge CLK_IN);
  endtask

  task automatic doReset(string tag);
    RST_N_IN = 1'b0;
    #1;
    checkOutput(tag, {rgb_valid, RGB_out}, 9'h000);
    model_reset();
    active = 1'b0;
    frame_start = 1'b0;
    score_evt = 1'b0;
    repeat (2) begin
      @(posedge CLK_IN);
      @(negedge CLK_IN);
    end
    RST_N_IN = 1'b1;
  endtask

  initial begin
    model_reset();
    ballX = 5'd3; ballY = 4'd4;
    active = 1'b1; xCoord = 10'd100; yCoord = 10'd130;
    repeat (3) @(negedge CLK_IN);
    checkOutput("reset_hold", {rgb_valid, RGB_out}, 9'h000);
    RST_N_IN = 1'b1;

    // first frame: ball at (3,4), latency check
    applyStimulus("first_fs", 0, 0, 0, 1, 0);
    applyStimulus("ball_px", 96, 128, 1, 0, 0);
    applyStimulus("ball_px", 127, 159, 1, 0, 0);
    applyStimulus("bg_px", 200, 300, 1, 0, 0);

    // paddle bounds including the clipped computer paddle
    playerPos = 4'd2; comPos = 4'd12;
    applyStimulus("paddle_fs", 0, 0, 0, 1, 0);
    for (int r = 0; r < 16; r++) applyStimulus("player_col", px(0), px(r), 1, 0, 0);
    for (int r = 0; r < 16; r++) applyStimulus("com_col", px(GW - 1), px(r), 1, 0, 0);

    // latching: mid-frame move is deferred
    ballX = 5'd3; ballY = 4'd4;
    applyStimulus("latch_fs", 0, 0, 0, 1, 0);
    ballX = 5'd7;
    for (int c = 0; c < GW; c++) applyStimulus("latch_old", px(c), px(4), 1, 0, 0);
    applyStimulus("latch_fs2", 0, 0, 0, 1, 0);
    for (int c = 0; c < GW; c++) applyStimulus("latch_new", px(c), px(4), 1, 0, 0);

    // priority and net
    net_en = 1'b1; ballX = 5'd10; ballY = 4'd4;
    applyStimulus("net_fs", 0, 0, 0, 1, 0);
    for (int r = 0; r < GH; r++) applyStimulus("net_col", px(10), px(r), 1, 0, 0);
    applyStimulus("blank_ball", px(10), px(4), 0, 0, 0);
    applyStimulus("ball_again", px(10), px(4), 1, 0, 0);
    applyStimulus("ball_again", px(10), px(4), 1, 0, 0);
    doReset("rst_mid");
    applyStimulus("rst_zero_pad", px(0), px(2), 1, 0, 0);
    applyStimulus("rst_zero_net", px(10), px(0), 1, 0, 0);
    applyStimulus("rst_zero_bg", px(5), px(8), 1, 0, 0);

    // blink after a score, then a coincident score/frame_start
    net_en = 1'b0; ballX = 5'd5; ballY = 4'd6;
    applyStimulus("flash_fs0", 0, 0, 0, 1, 0);
    applyStimulus("flash_se", 0, 0, 0, 0, 1);
    for (int f = 0; f < FLASH + 2; f++) begin
      applyStimulus("flash_fs", px(5), px(6), 1, 1, 0);
      applyStimulus("flash_px", px(5), px(6), 1, 0, 0);
    end
    applyStimulus("coinc_fs_se", px(5), px(6), 1, 1, 1);
    for (int f = 0; f < FLASH + 2; f++) begin
      applyStimulus("coinc_fs", px(5), px(6), 1, 1, 0);
      applyStimulus("coinc_px", px(5), px(6), 1, 0, 0);
      if (f == 1) applyStimulus("retrigger", px(5), px(6), 1, 0, 1);
    end

    // out-of-range ball and columns beyond the grid
    ballX = 5'd25; ballY = 4'd4; net_en = 1'b1;
    applyStimulus("range_fs", 0, 0, 0, 1, 0);
    for (int c = 0; c <= GW; c++)
      for (int r = 0; r <= GH; r++)
        applyStimulus("range_scan", px(c), px(r), 1, 0, 0);
    applyStimulus("x640", 640, px(4), 1, 0, 0);

    // random frames
    applyStimulus("rand_fs0", 0, 0, 0, 1, 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        ballX = 5'($urandom_range(0, 31));
        ballY = 4'($urandom_range(0, 15));
        playerPos = 4'($urandom_range(0, 15));
        comPos = 4'($urandom_range(0, 15));
        net_en = 1'($urandom_range(0, 1));
      end
      applyStimulus("random", int'($urandom_range(0, 799)), int'($urandom_range(0, 524)),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0,
                    $urandom_range(0, 299) == 0);
    end
    applyStimulus("flush", 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
